// File: rtl/simon_round_sequencer.sv
// Simon round sequencer: latches a colour pattern, plays the first `level` entries on the LEDs,
// then checks player presses against it and advances the level, wins or loses.
module simon_round_sequencer #(
  parameter int unsigned MAX_LEN        = 8,
  parameter int unsigned ON_CYCLES      = 25000000,
  parameter int unsigned OFF_CYCLES     = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [2*MAX_LEN-1:0]         pattern,
  input  logic                         btn_valid,
  input  logic [1:0]                   btn_color,
  output logic                         led_en,
  output logic [1:0]                   led_color,
  output logic                         busy,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic                         win,
  output logic                         lose
);

  localparam int unsigned LvlW      = $clog2(MAX_LEN + 1);
  localparam int unsigned MaxPhase0 = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned MaxPhase  = (TIMEOUT_CYCLES > MaxPhase0) ? TIMEOUT_CYCLES : MaxPhase0;
  localparam int unsigned CntW      = $clog2(MaxPhase + 1);

  localparam logic [CntW-1:0] OnLast  = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] OffLast = CntW'(OFF_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [LvlW-1:0] LvlOne  = LvlW'(1);
  localparam logic [LvlW-1:0] LvlMax  = LvlW'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StPause, StPlayOn, StPlayOff, StInput, StWin, StLose} state_e;

  state_e               state_q;
  logic [2*MAX_LEN-1:0] pat_q;
  logic [LvlW-1:0]      idx_q;
  logic [CntW-1:0]      cnt_q;

  logic [LvlW-1:0] idx_next;
  logic [1:0]      cur_color;
  logic [1:0]      next_color;
  logic            last_entry;

  assign idx_next   = idx_q + LvlOne;
  assign cur_color  = pat_q[2*idx_q +: 2];
  assign next_color = pat_q[2*idx_next +: 2];
  assign last_entry = (idx_q == level - LvlOne);
  assign busy       = state_q inside {StPause, StPlayOn, StPlayOff, StInput};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      led_en    <= 1'b0;
      led_color <= 2'b00;
      level     <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWin, StLose: begin
          if (start) begin
            pat_q   <= pattern;
            level   <= LvlOne;
            idx_q   <= '0;
            cnt_q   <= '0;
            win     <= 1'b0;
            lose    <= 1'b0;
            state_q <= StPause;
          end
        end
        StPause: begin
          if (cnt_q == OffLast) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            led_en    <= 1'b1;
            led_color <= pat_q[1:0];
            state_q   <= StPlayOn;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPlayOn: begin
          if (cnt_q == OnLast) begin
            cnt_q     <= '0;
            led_en    <= 1'b0;
            led_color <= 2'b00;
            state_q   <= StPlayOff;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StPlayOff: begin
          if (cnt_q == OffLast) begin
            cnt_q <= '0;
            if (last_entry) begin
              idx_q   <= '0;
              state_q <= StInput;
            end else begin
              idx_q     <= idx_next;
              led_en    <= 1'b1;
              led_color <= next_color;
              state_q   <= StPlayOn;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StInput: begin
          // A press on the final timeout cycle takes priority over the timeout.
          if (btn_valid) begin
            cnt_q <= '0;
            if (btn_color != cur_color) begin
              lose    <= 1'b1;
              state_q <= StLose;
            end else if (!last_entry) begin
              idx_q <= idx_next;
            end else if (level == LvlMax) begin
              win     <= 1'b1;
              state_q <= StWin;
            end else begin
              idx_q   <= '0;
              level   <= level + LvlOne;
              state_q <= StPause;
            end
          end else if (cnt_q == ToLast) begin
            cnt_q   <= '0;
            lose    <= 1'b1;
            state_q <= StLose;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_round_sequencer.sv
// Randomised bench for simon_round_sequencer: a game-rule model predicts the LED timeline and
// the outcome of every press, timeout and reset.
module tb_simon_round_sequencer;

  localparam int MaxLen = 4;
  localparam int OnCyc  = 3;
  localparam int OffCyc = 2;
  localparam int ToCyc  = 20;
  localparam int Period = OnCyc + OffCyc;

  logic                clk = 1'b0;
  logic                resetn;
  logic                start;
  logic [2*MaxLen-1:0] pattern;
  logic                btn_valid;
  logic [1:0]          btn_color;
  logic                led_en;
  logic [1:0]          led_color;
  logic                busy;
  logic [2:0]          level;
  logic                win;
  logic                lose;

  int checks = 0;
  int errors = 0;

  simon_round_sequencer #(
    .MAX_LEN       (MaxLen),
    .ON_CYCLES     (OnCyc),
    .OFF_CYCLES    (OffCyc),
    .TIMEOUT_CYCLES(ToCyc)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .pattern  (pattern),
    .btn_valid(btn_valid),
    .btn_color(btn_color),
    .led_en   (led_en),
    .led_color(led_color),
    .busy     (busy),
    .level    (level),
    .win      (win),
    .lose     (lose)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input int e_led, input int e_col, input int e_busy,
                             input int e_lvl, input int e_win, input int e_lose);
    check({tag, ".led_en"}, 32'(led_en), e_led);
    check({tag, ".led_color"}, 32'(led_color), e_col);
    check({tag, ".busy"}, 32'(busy), e_busy);
    check({tag, ".level"}, 32'(level), e_lvl);
    check({tag, ".win"}, 32'(win), e_win);
    check({tag, ".lose"}, 32'(lose), e_lose);
  endtask

  // mode: 0 random, 1 perfect, 2 timeout at level 2, 3 every press on the last allowed cycle,
  // 4 wrong second press (R instead of G) at level 2. abort_lvl>0 resets during that playback.
  task automatic play_game(input logic [7:0] gpat, input int mode, input int abort_lvl);
    int e_lvl = 0;
    int e_win = 0;
    int e_lose = 0;
    pattern   = gpat;
    start     = 1'b1;
    btn_valid = 1'($urandom_range(0, 1));
    btn_color = 2'($urandom);
    step();
    start     = 1'b0;
    btn_valid = 1'b0;
    pattern   = 8'($urandom);
    check_state("start", 0, 0, 1, 1, 0, 0);
    for (int lv = 1; lv <= MaxLen && e_win == 0 && e_lose == 0; lv++) begin
      for (int k = 0; k < OffCyc + lv * Period; k++) begin
        int  j;
        int  lit;
        logic [1:0] col;
        j   = (k - OffCyc) / Period;
        lit = (k >= OffCyc && ((k - OffCyc) % Period) < OnCyc) ? 1 : 0;
        col = (lit != 0) ? gpat[2*j +: 2] : 2'b00;
        check_state("play", lit, int'(col), 1, lv, 0, 0);
        if (lv == abort_lvl && k == OffCyc + 1) begin
          resetn    = 1'b0;
          start     = 1'b1;
          btn_valid = 1'b1;
          step();
          check_state("rst1", 0, 0, 0, 0, 0, 0);
          step();
          check_state("rst2", 0, 0, 0, 0, 0, 0);
          resetn    = 1'b1;
          start     = 1'b0;
          btn_valid = 1'b0;
          step();
          check_state("rst_idle", 0, 0, 0, 0, 0, 0);
          return;
        end
        btn_valid = 1'($urandom_range(0, 3) == 0);
        btn_color = 2'($urandom);
        start     = 1'($urandom_range(0, 7) == 0);
        step();
        btn_valid = 1'b0;
        start     = 1'b0;
      end
      for (int i = 0; i < lv && e_lose == 0; i++) begin
        int d;
        int wrong;
        logic [1:0] col;
        d     = $urandom_range(0, 3);
        wrong = 0;
        if (mode == 0) begin
          int r = $urandom_range(0, 99);
          if (r < 4) d = ToCyc;
          else if (r < 10) d = ToCyc - 1;
          wrong = ($urandom_range(0, 99) < 8) ? 1 : 0;
        end else if (mode == 2 && lv == 2 && i == 0) begin
          d = ToCyc;
        end else if (mode == 3) begin
          d = ToCyc - 1;
        end
        col = gpat[2*i +: 2];
        if (wrong != 0) col = col ^ 2'($urandom_range(1, 3));
        if (mode == 4 && lv == 2 && i == 1) col = 2'b10;
        for (int w = 0; w < d && w < ToCyc; w++) begin
          check_state("wait", 0, 0, 1, lv, 0, 0);
          step();
        end
        if (d >= ToCyc) begin
          e_lvl  = lv;
          e_lose = 1;
          check_state("timeout", 0, 0, 0, lv, 0, 1);
        end else begin
          btn_valid = 1'b1;
          btn_color = col;
          step();
          btn_valid = 1'b0;
          if (col != gpat[2*i +: 2]) begin
            e_lvl  = lv;
            e_lose = 1;
            check_state("wrong", 0, 0, 0, lv, 0, 1);
          end else if (i < lv - 1) begin
            check_state("advance", 0, 0, 1, lv, 0, 0);
          end else if (lv == MaxLen) begin
            e_lvl = MaxLen;
            e_win = 1;
            check_state("win", 0, 0, 0, MaxLen, 1, 0);
          end
        end
      end
    end
    // Presses after the game ends must leave the result untouched.
    for (int h = 0; h < 3; h++) begin
      btn_valid = 1'($urandom_range(0, 1));
      btn_color = 2'($urandom);
      step();
      btn_valid = 1'b0;
      check_state("hold", 0, 0, 0, e_lvl, e_win, e_lose);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    start     = 1'b0;
    btn_valid = 1'b0;
    btn_color = 2'b00;
    pattern   = '0;
    step();
    step();
    check_state("reset", 0, 0, 0, 0, 0, 0);
    resetn    = 1'b1;
    btn_valid = 1'b1;
    step();
    btn_valid = 1'b0;
    check_state("idle_btn", 0, 0, 0, 0, 0, 0);

    play_game(8'b11_10_01_00, 1, 0);
    play_game(8'b11_10_01_00, 4, 0);
    play_game(8'b11_10_01_00, 2, 0);
    play_game(8'b11_10_01_00, 3, 0);
    play_game(8'b11_10_01_00, 1, 3);
    for (int g = 0; g < 25; g++) begin
      play_game(8'($urandom), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
